dispatch_nw: RTL and testbench

- Parametrised, clocked N-wide dispatch stage between rename and the reservation stations (RS) / reorder buffer (ROB).
- Each cycle it accepts a bundle of up to WIDTH renamed uops. It allocates one free RS slot and one ROB slot per uop (ROB in program order) and steers each uop to an FU: ALU ops round-robin across ALU FUs, LW/SW to the memory FU.
- It owns the RS-occupancy bitmap, the ROB head/tail/count and the physical-register ready scoreboard.
- New relative to the previous generation: it stalls cleanly when resources are exhausted, and it handles intra-bundle RAW hazards.

---
 rtl/dispatch_nw_pkg.sv | 30 +++
 rtl/dispatch_nw_pick.sv | 42 ++++
 rtl/dispatch_nw.sv | 209 ++++++++++++++++++++
 tb/tb_dispatch_nw.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dispatch_nw_pkg.sv
// Shared types and constants for the N-wide dispatch stage.
//   uop_t       : renamed micro-op as delivered by rename
//   OP_IMM, OP, LOAD, STORE : major opcodes the dispatch logic decodes
//   FU_MEM      : FU index of the memory unit (one past the last ALU)
//   is_mem()    : true for opcodes steered to the memory FU
package dispatch_nw_pkg;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [5:0]  ps1;
    logic [5:0]  ps2;
    logic [5:0]  pd;
    logic [31:0] imm;
  } uop_t;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  localparam int NUM_ALU_DFLT = 2;
  localparam int FU_MEM       = NUM_ALU_DFLT;

  function automatic logic is_mem(input logic [6:0] opc);
    return (opc == LOAD) || (opc == STORE);
  endfunction

endpackage

// File: rtl/dispatch_nw_pick.sv
// pick_n_free: WIDTH-way lowest-index priority picker over a free bitmap.
//   free_i : 1 = slot free
//   need_i : number of slots requested this cycle
//   idx_o  : idx_o[k] is the k-th lowest-index free slot
//   ok_o   : at least need_i slots are free
module pick_n_free
  import dispatch_nw_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int RS_DEPTH = 16,
  parameter int NW       = $clog2(WIDTH) + 1,
  localparam int IW      = $clog2(RS_DEPTH)
) (
  input  logic [RS_DEPTH-1:0]       free_i,
  input  logic [NW-1:0]             need_i,
  output logic [WIDTH-1:0][IW-1:0]  idx_o,
  output logic                      ok_o
);

  always_comb begin
    logic [RS_DEPTH-1:0] avail;
    logic                found;
    logic [IW:0]         cnt;
    avail = free_i;
    cnt   = '0;
    for (int s = 0; s < RS_DEPTH; s++) cnt = cnt + (IW+1)'(free_i[s]);
    for (int k = 0; k < WIDTH; k++) begin
      idx_o[k] = '0;
      found    = 1'b0;
      // Each lane takes the lowest slot not already claimed by a lower lane.
      for (int s = 0; s < RS_DEPTH; s++) begin
        if (!found && avail[s]) begin
          idx_o[k] = IW'(s);
          avail[s] = 1'b0;
          found    = 1'b1;
        end
      end
    end
    ok_o = (cnt >= (IW+1)'(need_i));
  end

endmodule

// File: rtl/dispatch_nw.sv
// dispatch_nw: N-wide dispatch between rename and the RS/ROB.
// Allocates RS and ROB slots, steers uops to FUs, computes source-ready
// flags and owns the RS occupancy bitmap, ROB pointers and PRF scoreboard.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_lane_v/in_uop : incoming bundle (lanes packed from 0)
//   in_ready                  : whole bundle can be accepted (state only)
//   rs_we/rs_idx/rob_idx/fu_idx/src1_rdy/src2_rdy/out_uop : registered
//                               per-lane dispatch results
//   rs_free_v/rs_free_idx     : RS slots released by issue
//   wb_v/wb_pd                : writeback broadcasts
//   commit_cnt                : ROB entries retired at head
//   flush                     : squash RS and ROB contents
//   rob_head                  : oldest ROB entry
module dispatch_nw
  import dispatch_nw_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int RS_DEPTH  = 16,
  parameter int ROB_DEPTH = 16,
  parameter int NUM_PREGS = 64,
  parameter int NUM_ALU   = NUM_ALU_DFLT,
  localparam int RSW  = $clog2(RS_DEPTH),
  localparam int ROBW = $clog2(ROB_DEPTH),
  localparam int NFU  = NUM_ALU + 1,
  localparam int FUW  = $clog2(NUM_ALU + 1),
  localparam int CW   = $clog2(WIDTH) + 1,
  localparam int PW   = $clog2(NUM_PREGS),
  localparam int RRW  = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_lane_v,
  input  uop_t [WIDTH-1:0]            in_uop,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            rs_we,
  output logic [WIDTH-1:0][RSW-1:0]   rs_idx,
  output logic [WIDTH-1:0][ROBW-1:0]  rob_idx,
  output logic [WIDTH-1:0][FUW-1:0]   fu_idx,
  output logic [WIDTH-1:0]            src1_rdy,
  output logic [WIDTH-1:0]            src2_rdy,
  output uop_t [WIDTH-1:0]            out_uop,
  input  logic [NFU-1:0]              rs_free_v,
  input  logic [NFU-1:0][RSW-1:0]     rs_free_idx,
  input  logic [NFU-1:0]              wb_v,
  input  logic [NFU-1:0][PW-1:0]      wb_pd,
  input  logic [CW-1:0]               commit_cnt,
  input  logic                        flush,
  output logic [ROBW-1:0]             rob_head
);

  logic [RS_DEPTH-1:0]  rs_busy_q, rs_busy_d;
  logic [ROBW-1:0]      rob_head_q, rob_head_d, rob_tail_q, rob_tail_d;
  logic [ROBW:0]        rob_cnt_q, rob_cnt_d, rob_room;
  logic [NUM_PREGS-1:0] sb_q, sb_d;
  logic [RRW-1:0]       rr_q, rr_d;
  logic [CW-1:0]        n_lanes;
  logic                 pick_ok, accept;

  logic [WIDTH-1:0][RSW-1:0]  pick_idx;
  logic [WIDTH-1:0][ROBW-1:0] rob_idx_d;
  logic [WIDTH-1:0][FUW-1:0]  fu_d;
  logic [WIDTH-1:0]           s1_d, s2_d;

  logic [WIDTH-1:0]           rs_we_q;
  logic [WIDTH-1:0][RSW-1:0]  rs_idx_q;
  logic [WIDTH-1:0][ROBW-1:0] rob_idx_q;
  logic [WIDTH-1:0][FUW-1:0]  fu_idx_q;
  logic [WIDTH-1:0]           src1_q, src2_q;
  uop_t [WIDTH-1:0]           out_uop_q;

  // Scoreboard lookup with same-cycle writeback bypass.
  function automatic logic src_ready(input logic [PW-1:0] p,
                                     input logic [NUM_PREGS-1:0] sb,
                                     input logic [NFU-1:0] wv,
                                     input logic [NFU-1:0][PW-1:0] wp);
    logic r;
    r = sb[p];
    for (int f = 0; f < NFU; f++) if (wv[f] && (wp[f] == p)) r = 1'b1;
    return r;
  endfunction

  always_comb begin
    n_lanes = '0;
    for (int k = 0; k < WIDTH; k++) n_lanes = n_lanes + CW'(in_lane_v[k]);
  end

  pick_n_free #(
    .WIDTH    (WIDTH),
    .RS_DEPTH (RS_DEPTH),
    .NW       (CW)
  ) u_pick (
    .free_i (~rs_busy_q),
    .need_i (n_lanes),
    .idx_o  (pick_idx),
    .ok_o   (pick_ok)
  );

  assign rob_room = (ROBW+1)'(ROB_DEPTH) - rob_cnt_q;
  assign in_ready = !rst && !flush && pick_ok && (rob_room >= (ROBW+1)'(n_lanes));
  assign accept   = in_valid && in_ready;

  // Per-lane steering, ROB slot and source readiness.
  always_comb begin
    uop_t u;
    rr_d = rr_q;
    for (int k = 0; k < WIDTH; k++) begin
      u            = in_uop[k];
      fu_d[k]      = '0;
      s1_d[k]      = 1'b0;
      s2_d[k]      = 1'b0;
      rob_idx_d[k] = rob_tail_q + ROBW'(k);
      if (in_lane_v[k]) begin
        if (is_mem(u.opcode)) begin
          fu_d[k] = FUW'(NUM_ALU);
        end else begin
          fu_d[k] = FUW'(rr_d);
          rr_d    = (rr_d == RRW'(NUM_ALU - 1)) ? '0 : rr_d + RRW'(1);
        end
      end
      if ((u.opcode == OP_IMM) || (u.opcode == OP))
        s1_d[k] = src_ready(u.ps1, sb_q, wb_v, wb_pd);
      if (u.opcode == OP)
        s2_d[k] = src_ready(u.ps2, sb_q, wb_v, wb_pd);
      else if ((u.opcode == OP_IMM) || (u.opcode == LOAD))
        s2_d[k] = 1'b1;
      // An older lane in the same bundle produces this source: not ready yet.
      for (int j = 0; j < k; j++) begin
        if (in_lane_v[j] && (in_uop[j].pd == u.ps1)) s1_d[k] = 1'b0;
        if (in_lane_v[j] && (in_uop[j].pd == u.ps2) && (u.opcode == OP)) s2_d[k] = 1'b0;
      end
    end
  end

  // Next-state for RS bitmap, ROB pointers and scoreboard.
  always_comb begin
    rs_busy_d  = rs_busy_q;
    sb_d       = sb_q;
    rob_tail_d = rob_tail_q;
    rob_head_d = rob_head_q + ROBW'(commit_cnt);
    rob_cnt_d  = rob_cnt_q - (ROBW+1)'(commit_cnt);
    for (int f = 0; f < NFU; f++) begin
      if (rs_free_v[f]) rs_busy_d[rs_free_idx[f]] = 1'b0;
      if (wb_v[f])      sb_d[wb_pd[f]]            = 1'b1;
    end
    if (accept) begin
      // Clear after writeback so a dispatch clear wins on the same pd.
      for (int k = 0; k < WIDTH; k++) begin
        if (in_lane_v[k]) begin
          rs_busy_d[pick_idx[k]] = 1'b1;
          if (in_uop[k].pd != '0) sb_d[in_uop[k].pd] = 1'b0;
        end
      end
      rob_tail_d = rob_tail_q + ROBW'(n_lanes);
      rob_cnt_d  = rob_cnt_d + (ROBW+1)'(n_lanes);
    end
    if (flush) begin
      rs_busy_d  = '0;
      rob_head_d = rob_tail_q;
      rob_cnt_d  = '0;
    end
  end

  // ---- register stage: control state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_busy_q  <= '0;
      rob_head_q <= '0;
      rob_tail_q <= '0;
      rob_cnt_q  <= '0;
      sb_q       <= '1;
      rr_q       <= '0;
      rs_we_q    <= '0;
    end else begin
      rs_busy_q  <= rs_busy_d;
      rob_head_q <= rob_head_d;
      rob_tail_q <= rob_tail_d;
      rob_cnt_q  <= rob_cnt_d;
      sb_q       <= sb_d;
      if (accept) rr_q <= rr_d;
      rs_we_q    <= accept ? in_lane_v : '0;
    end
  end

  // ---- register stage: per-lane dispatch payload ----
  always_ff @(posedge clk) begin
    if (accept) begin
      rs_idx_q  <= pick_idx;
      rob_idx_q <= rob_idx_d;
      fu_idx_q  <= fu_d;
      src1_q    <= s1_d;
      src2_q    <= s2_d;
      out_uop_q <= in_uop;
    end
  end

  assign rs_we    = rs_we_q;
  assign rs_idx   = rs_idx_q;
  assign rob_idx  = rob_idx_q;
  assign fu_idx   = fu_idx_q;
  assign src1_rdy = src1_q;
  assign src2_rdy = src2_q;
  assign out_uop  = out_uop_q;
  assign rob_head = rob_head_q;

  commit_le_count: assert property (@(posedge clk) disable iff (rst)
    ((ROBW+1)'(commit_cnt) <= rob_cnt_q));

endmodule

// File: tb/tb_dispatch_nw.sv
module tb_dispatch_nw;
  import dispatch_nw_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst, in_valid, in_ready, flush;
  logic [1:0]           in_lane_v, rs_we, src1_rdy, src2_rdy, commit_cnt;
  uop_t [1:0]           in_uop, out_uop;
  logic [1:0][3:0]      rs_idx, rob_idx;
  logic [1:0][1:0]      fu_idx;
  logic [2:0]           rs_free_v, wb_v;
  logic [2:0][3:0]      rs_free_idx;
  logic [2:0][5:0]      wb_pd;
  logic [3:0]           rob_head;

  always #5 clk = ~clk;

  dispatch_nw dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_lane_v(in_lane_v),
    .in_uop(in_uop), .in_ready(in_ready), .rs_we(rs_we), .rs_idx(rs_idx),
    .rob_idx(rob_idx), .fu_idx(fu_idx), .src1_rdy(src1_rdy),
    .src2_rdy(src2_rdy), .out_uop(out_uop), .rs_free_v(rs_free_v),
    .rs_free_idx(rs_free_idx), .wb_v(wb_v), .wb_pd(wb_pd),
    .commit_cnt(commit_cnt), .flush(flush), .rob_head(rob_head)
  );

  typedef struct { int rs; int rob; int fu; int s1; int s2; uop_t u; } exp_t;
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  uop_t Z;
  exp_t NE;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic uop_t mk(input logic [6:0] opc, input int pd, input int ps1, input int ps2);
    uop_t u;
    u        = '0;
    u.opcode = opc;
    u.pd     = 6'(pd);
    u.ps1    = 6'(ps1);
    u.ps2    = 6'(ps2);
    u.func3  = 3'(pd);
    u.imm    = 32'(pd * 256 + ps1 * 16 + ps2);
    return u;
  endfunction

  function automatic exp_t ex(input int rs, input int rob, input int fu,
                              input int s1, input int s2, input uop_t u);
    exp_t e;
    e.rs = rs; e.rob = rob; e.fu = fu; e.s1 = s1; e.s2 = s2; e.u = u;
    return e;
  endfunction

  // Monitor: pops one expectation per lane that the DUT dispatches.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (rs_we[k] === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dispatch: lane %0d rs_idx %0d, expected no dispatch", k, rs_idx[k]);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rs_idx[%0d]", k),   rs_idx[k],   e.rs);
          chk($sformatf("rob_idx[%0d]", k),  rob_idx[k],  e.rob);
          chk($sformatf("fu_idx[%0d]", k),   fu_idx[k],   e.fu);
          chk($sformatf("src1_rdy[%0d]", k), src1_rdy[k], e.s1);
          chk($sformatf("src2_rdy[%0d]", k), src2_rdy[k], e.s2);
          chk($sformatf("out_uop[%0d]", k),  out_uop[k],  e.u);
        end
      end
    end
  end

  // One cycle: present a bundle (lv=0 means idle), check in_ready, and
  // record expectations for lanes that should be accepted.
  task automatic step(input logic [1:0] lv, input uop_t u0, input uop_t u1,
                      input exp_t e0, input exp_t e1, input bit rdy);
    in_valid  = |lv;
    in_lane_v = lv;
    in_uop[0] = u0;
    in_uop[1] = u1;
    @(negedge clk);
    chk("in_ready", in_ready, rdy);
    if (rdy && in_valid) begin
      if (lv[0]) exp_q.push_back(e0);
      if (lv[1]) exp_q.push_back(e1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_lane_v = '0; rs_free_v = '0; wb_v = '0;
    commit_cnt = '0; flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    uop_t a, b;
    Z = '0;
    rst = 1'b1; flush = 1'b0; commit_cnt = '0;
    rs_free_v = '0; rs_free_idx = '0; wb_v = '0; wb_pd = '0;
    in_valid = 1'b1; in_lane_v = 2'b11;
    in_uop[0] = mk(OP_IMM, 3, 1, 0); in_uop[1] = mk(OP_IMM, 4, 1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_rs_we", rs_we, 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_lane_v = '0;
    chk("reset_rob_head", rob_head, 0);

    // ADDI pd5 ps1=1 ; ADD pd6 ps1=5 (RAW) ps2=2
    a = mk(OP_IMM, 5, 1, 0); b = mk(OP, 6, 5, 2);
    step(2'b11, a, b, ex(0, 0, 0, 1, 1, a), ex(1, 1, 1, 0, 1, b), 1);
    // scoreboard[5], [6] now busy
    a = mk(OP, 7, 5, 6);
    step(2'b01, a, Z, ex(2, 2, 0, 0, 0, a), NE, 1);
    // LW / SW to memory FU, rr untouched (currently 1)
    a = mk(LOAD, 8, 1, 0); b = mk(STORE, 0, 1, 8);
    step(2'b11, a, b, ex(3, 3, 2, 0, 1, a), ex(4, 4, 2, 0, 0, b), 1);
    a = mk(OP_IMM, 10, 8, 0);
    step(2'b01, a, Z, ex(5, 5, 1, 0, 1, a), NE, 1);

    // Fill remaining 10 RS slots (and the ROB)
    for (int i = 0; i < 5; i++) begin
      a = mk(OP_IMM, (i == 0) ? 9 : 11, 1, 0); b = mk(OP_IMM, 12, 1, 0);
      step(2'b11, a, b, ex(6 + 2*i, 6 + 2*i, 0, 1, 1, a), ex(7 + 2*i, 7 + 2*i, 1, 1, 1, b), 1);
    end

    // Full: stall, while freeing RS slot 3 and committing 2
    a = mk(OP_IMM, 13, 1, 0);
    rs_free_v = 3'b001; rs_free_idx[0] = 4'd3; commit_cnt = 2'd2;
    step(2'b01, a, Z, NE, NE, 0);
    step(2'b01, a, Z, ex(3, 0, 0, 1, 1, a), NE, 1);

    // Free RS 5 and 7, commit 1 -> ROB count 14
    rs_free_v = 3'b011; rs_free_idx[0] = 4'd5; rs_free_idx[1] = 4'd7; commit_cnt = 2'd1;
    step(2'b00, Z, Z, NE, NE, 1);
    // Dispatch 2 with 2 ROB slots left while committing 2
    a = mk(OP_IMM, 11, 1, 0); b = mk(OP_IMM, 12, 1, 0);
    commit_cnt = 2'd2;
    step(2'b11, a, b, ex(5, 1, 1, 1, 1, a), ex(7, 2, 0, 1, 1, b), 1);
    chk("rob_head_after_commits", rob_head, 5);

    // Writeback bypass of pd9 in the dispatch cycle
    rs_free_v = 3'b001; rs_free_idx[0] = 4'd0;
    step(2'b00, Z, Z, NE, NE, 1);
    a = mk(OP, 14, 9, 1);
    wb_v = 3'b001; wb_pd[0] = 6'd9;
    step(2'b01, a, Z, ex(0, 3, 1, 1, 1, a), NE, 1);
    rs_free_v = 3'b001; rs_free_idx[0] = 4'd2;
    step(2'b00, Z, Z, NE, NE, 1);
    a = mk(OP_IMM, 15, 9, 0);
    step(2'b01, a, Z, ex(2, 4, 0, 1, 1, a), NE, 1);

    // Flush: not ready this cycle, RS/ROB empty after
    a = mk(OP_IMM, 16, 1, 0);
    flush = 1'b1;
    step(2'b01, a, Z, NE, NE, 0);
    chk("flush_rob_head", rob_head, 5);
    chk("flush_rs_we", rs_we, 0);

    // Dispatch clear beats same-cycle writeback of pd20
    a = mk(OP_IMM, 20, 1, 0); b = mk(OP, 21, 3, 4);
    wb_v = 3'b001; wb_pd[0] = 6'd20;
    step(2'b11, a, b, ex(0, 5, 1, 1, 1, a), ex(1, 6, 0, 1, 1, b), 1);
    a = mk(OP, 22, 20, 21);
    step(2'b01, a, Z, ex(2, 7, 1, 0, 0, a), NE, 1);
    step(2'b00, Z, Z, NE, NE, 1);
    @(negedge clk);
    chk("pending_expectations", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
